// File: rtl/sha3_bridge_pkg.sv
// Shared types and helpers for the UART <-> SHA3 byte/word bridge.
package sha3_bridge_pkg;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_PUSH,
    S_WAIT_DIG,
    S_TX,
    S_EOL
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Lowercase ASCII for one nibble: '0'..'9' = 0x30.., 'a'..'f' = 0x61..
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/digest_tx_serializer.sv
// Turns one latched digest word into TX bytes (raw, LSB first) or hex chars,
// and emits the CR LF line ending when asked to.
module digest_tx_serializer
  import sha3_bridge_pkg::*;
#(
  parameter int HEX_OUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        tx_en,
  input  logic        eol_en,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        word_done,
  output logic        eol_done
);

  logic [31:0] word_q;
  logic [1:0]  out_byte;
  logic        nib_lo;
  logic        eol_lf;
  logic [7:0]  cur_byte;
  logic        fire;

  assign tx_valid = tx_en | eol_en;
  assign fire     = tx_valid & tx_ready;
  assign cur_byte = word_q[{out_byte, 3'b000} +: 8];

  // tx_data is a pure function of held registers, so it cannot move during a stall
  always_comb begin
    tx_data = 8'h00;
    if (eol_en) begin
      tx_data = eol_lf ? LF : CR;
    end else if (tx_en) begin
      if (HEX_OUT != 0) tx_data = nib2hex(nib_lo ? cur_byte[3:0] : cur_byte[7:4]);
      else              tx_data = cur_byte;
    end
  end

  assign word_done = tx_en & fire & (out_byte == 2'd3) & ((HEX_OUT == 0) | nib_lo);
  assign eol_done  = eol_en & fire & eol_lf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      out_byte <= '0;
      nib_lo   <= 1'b0;
      eol_lf   <= 1'b0;
    end else begin
      if (load) begin
        word_q   <= word_in;
        out_byte <= '0;
        nib_lo   <= 1'b0;
      end else if (tx_en && fire) begin
        if (HEX_OUT == 0) begin
          out_byte <= out_byte + 2'd1;
        end else begin
          nib_lo <= ~nib_lo;
          if (nib_lo) out_byte <= out_byte + 2'd1;
        end
      end
      if (eol_en && fire) eol_lf <= ~eol_lf;
    end
  end

endmodule

// File: rtl/uart_hash_bridge.sv
// Packs UART RX bytes little-endian into SHA3 input words and streams the
// digest back out over UART TX.
module uart_hash_bridge
  import sha3_bridge_pkg::*;
#(
  parameter int         DIGEST_WORDS = 8,
  parameter logic [7:0] TERM_BYTE    = 8'h0D,
  parameter bit         ALT_TERM_EN  = 1'b1,
  parameter int         HEX_OUT      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] sha3_in_data,
  output logic [2:0]  sha3_in_bytes,
  output logic        sha3_in_last,
  output logic        sha3_in_valid,
  input  logic        sha3_in_ready,
  input  logic [31:0] sha3_out_data,
  input  logic        sha3_out_valid,
  output logic        sha3_out_ready,
  output logic        busy
);

  localparam logic [3:0] LAST_WORD = 4'(DIGEST_WORDS - 1);

  state_t      state_q, state_d;
  logic        alive_q;
  logic [1:0]  byte_cnt_q;
  logic [3:0]  word_cnt_q;
  logic [31:0] pack_q;
  logic [2:0]  bytes_q;
  logic        last_q;
  logic        is_term, rx_fire, more_words, load;
  logic        tx_en, eol_en, word_done, eol_done;

  assign is_term    = (rx_data == TERM_BYTE) || (ALT_TERM_EN && (rx_data == LF));
  assign rx_fire    = rx_valid & rx_ready;
  assign more_words = word_cnt_q < LAST_WORD;
  assign load       = sha3_out_ready & sha3_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT:  if (rx_fire && (is_term || byte_cnt_q == 2'd3)) state_d = S_PUSH;
      S_PUSH:     if (sha3_in_ready) state_d = last_q ? S_WAIT_DIG : S_COLLECT;
      S_WAIT_DIG: if (sha3_out_valid) state_d = S_TX;
      S_TX: begin
        if (word_done) begin
          if (more_words)        state_d = S_WAIT_DIG;
          else if (HEX_OUT != 0) state_d = S_EOL;
          else                   state_d = S_COLLECT;
        end
      end
      S_EOL:      if (eol_done) state_d = S_COLLECT;
      default:    state_d = S_COLLECT;
    endcase
  end

  // alive_q keeps rx_ready low while rst is held and for the release edge
  always_comb begin
    rx_ready       = 1'b0;
    sha3_in_valid  = 1'b0;
    sha3_out_ready = 1'b0;
    tx_en          = 1'b0;
    eol_en         = 1'b0;
    busy           = (state_q != S_COLLECT);
    unique case (state_q)
      S_COLLECT:  rx_ready       = alive_q;
      S_PUSH:     sha3_in_valid  = 1'b1;
      S_WAIT_DIG: sha3_out_ready = 1'b1;
      S_TX:       tx_en          = 1'b1;
      S_EOL:      eol_en         = 1'b1;
      default:    rx_ready       = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q    <= 1'b0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      pack_q     <= '0;
      bytes_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (rx_fire) begin
        if (is_term) begin
          bytes_q    <= {1'b0, byte_cnt_q};
          last_q     <= 1'b1;
          byte_cnt_q <= '0;
          if (byte_cnt_q == 2'd0) pack_q <= '0;
        end else begin
          if (byte_cnt_q == 2'd0) pack_q <= {24'h0, rx_data};
          else                    pack_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            bytes_q <= 3'd4;
            last_q  <= 1'b0;
          end
        end
      end
      // In hex mode the count is cleared once the line ending has gone out
      if (word_done) begin
        if (more_words)        word_cnt_q <= word_cnt_q + 4'd1;
        else if (HEX_OUT == 0) word_cnt_q <= '0;
      end
      if (eol_done) word_cnt_q <= '0;
    end
  end

  assign sha3_in_data  = pack_q;
  assign sha3_in_bytes = bytes_q;
  assign sha3_in_last  = last_q;

  digest_tx_serializer #(
    .HEX_OUT (HEX_OUT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word_in   (sha3_out_data),
    .tx_en     (tx_en),
    .eol_en    (eol_en),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .word_done (word_done),
    .eol_done  (eol_done)
  );

endmodule
